// File: rtl/cnn_mac_accum.sv
// Window accumulator for unsigned CNN products. It sums beats until prod_last or MAX_LEN, then holds the result for a valid/ready handshake.
// Optional macro CNN_MAC_ACCUM_SATURATE_EN: clamp the sum on overflow instead of wrapping.
module cnn_mac_accum #(
  parameter int DIN_WIDTH = 9,
  parameter int ACC_WIDTH = 16,
  parameter int MAX_LEN   = 256,
  parameter int CNT_WIDTH = 9
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  input  logic                 prod_valid,
  output logic                 prod_ready,
  input  logic [DIN_WIDTH-1:0] prod_data,
  input  logic                 prod_last,
  output logic                 sum_valid,
  input  logic                 sum_ready,
  output logic [ACC_WIDTH-1:0] sum_data,
  output logic [CNT_WIDTH-1:0] sum_count,
  output logic                 sum_ovf,
  output logic                 sum_len_err
);

  localparam int PAD = ACC_WIDTH + 1 - DIN_WIDTH;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [ACC_WIDTH-1:0] acc;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 ovf;

  logic                 accept;
  logic [ACC_WIDTH:0]   add_full;
  logic                 carry;
  logic [ACC_WIDTH-1:0] acc_next;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic                 len_hit;
  logic                 load_sum;
  logic                 clear_win;

  assign prod_ready = (state == ACCUM);
  assign sum_valid  = (state == HOLD);
  assign accept     = prod_valid && prod_ready;

  // The extra top bit of add_full is the carry-out that flags overflow.
  assign add_full = {1'b0, acc} + {{PAD{1'b0}}, prod_data};
  assign carry    = add_full[ACC_WIDTH];
  assign cnt_inc  = cnt + CNT_WIDTH'(1);
  assign len_hit  = (cnt_inc == CNT_WIDTH'(MAX_LEN));

  always_comb begin
    acc_next = add_full[ACC_WIDTH-1:0];
`ifdef CNN_MAC_ACCUM_SATURATE_EN
    // A saturated acc stays pinned at full scale: every later nonzero add carries again.
    if (carry) acc_next = '1;
`endif
  end

  always_ff @(posedge ap_clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (ap_rst) state <= ACCUM;
    else        state <= state_next;
  end

  always_comb begin
    // NOTE: each variable gets a default before the case so no path can infer a latch.
    state_next = state;
    load_sum   = 1'b0;
    clear_win  = 1'b0;
    case (state)
      ACCUM: begin
        if (accept && (prod_last || len_hit)) begin
          state_next = HOLD;
          load_sum   = 1'b1;
        end
      end
      HOLD: begin
        if (sum_ready) begin
          state_next = ACCUM;
          clear_win  = 1'b1;
        end
      end
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clear_win) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (accept) begin
      acc <= acc_next;
      cnt <= cnt_inc;
      ovf <= ovf | carry;
    end
  end

  // The result registers load only when a window closes, so they hold steady under backpressure.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      sum_data    <= '0;
      sum_count   <= '0;
      sum_ovf     <= 1'b0;
      sum_len_err <= 1'b0;
    end else if (load_sum) begin
      sum_data    <= acc_next;
      sum_count   <= cnt_inc;
      sum_ovf     <= ovf | carry;
      sum_len_err <= ~prod_last;
    end
  end

endmodule
